// File: rtl/switch_ingress_parser_pkg.sv
// Shared switch ingress definitions: framing constants, parser state encoding
// and the packet FIFO entry layout.
package switch_ingress_parser_pkg;

  localparam logic [7:0]  SOF_BYTE  = 8'hFF;
  localparam int unsigned HDR_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DA,
    ST_SA,
    ST_LEN,
    ST_PAY,
    ST_PAR,
    ST_EOF,
    ST_SKIP
  } parser_state_e;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/parser_commit_fifo.sv
// Packet FIFO with commit/rollback: only bytes behind the commit pointer are
// visible to the reader, so a packet can be discarded after being written.
module parser_commit_fifo
  import switch_ingress_parser_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  fifo_entry_t              wr_entry_i,
  input  logic                     commit_i,
  input  logic                     rollback_i,
  input  logic                     rd_en_i,
  output fifo_entry_t              rd_entry_o,
  output logic                     rd_valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] cmt_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] used;
  logic          wr_fire;
  logic          rd_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign used       = wr_ptr_q - rd_ptr_q;
  assign full_o     = (used == PW'(DEPTH));
  assign free_o     = PW'(DEPTH) - used;
  assign rd_valid_o = (rd_ptr_q != cmt_ptr_q);
  assign rd_entry_o = rd_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign wr_fire    = wr_en_i && !full_o;
  assign rd_fire    = rd_en_i && rd_valid_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (rollback_i) begin
        wr_ptr_q <= cmt_ptr_q;
      end else if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (commit_i) begin
        cmt_ptr_q <= wr_ptr_q;
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_i;
    end
  end

endmodule

// File: rtl/switch_ingress_parser.sv
// Switch port ingress parser: delineates SOF/DA/SA/LEN/PAYLOAD/PAR/SOF frames,
// buffers good packets and replays them on a valid/ready stream.
// Optional parity checking is enabled by SWITCH_PARSER_PARITY_CHECK_EN.
module switch_ingress_parser
  import switch_ingress_parser_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       sw_enable_in,
  output logic       read_out,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       pkt_drop
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = 9;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [PW-1:0] ROOM_NEED = PW'(MAX_LEN + HDR_BYTES);

  parser_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             par_ok_q;
  logic             ovf_q;
  logic             read_out_q;
  logic             pkt_ok_q;
  logic             pkt_drop_q;

  logic             wr_en;
  fifo_entry_t      wr_entry;
  logic             commit;
  logic             rollback;
  logic             par_good;
  logic             len_big;
  logic             fifo_full;
  fifo_entry_t      rd_entry;
  logic             rd_valid;
  logic [PW-1:0]    free_cnt;

  assign len_big = (data_in > MAX_LEN_B);

`ifdef SWITCH_PARSER_PARITY_CHECK_EN
  logic [7:0] par_q;

  // Running XOR over every byte that is stored for the packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      par_q <= '0;
    end else if (sw_enable_in) begin
      if (state_q == ST_IDLE) begin
        par_q <= '0;
      end else if (wr_en) begin
        par_q <= par_q ^ data_in;
      end
    end
  end

  assign par_good = (data_in == par_q);
`else
  assign par_good = 1'b1;
`endif

  // FIFO strobes decoded from the state and the byte accepted this edge.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = '{sop: 1'b0, eop: 1'b0, data: data_in};
    commit   = 1'b0;
    rollback = 1'b0;
    if (sw_enable_in) begin
      case (state_q)
        ST_DA: begin
          wr_en        = 1'b1;
          wr_entry.sop = 1'b1;
        end
        ST_SA: wr_en = 1'b1;
        ST_LEN: begin
          if (len_big) begin
            rollback = 1'b1;
          end else begin
            wr_en        = 1'b1;
            wr_entry.eop = (data_in == 8'd0);
          end
        end
        ST_PAY: begin
          wr_en        = 1'b1;
          wr_entry.eop = (cnt_q == CNT_W'(1));
        end
        ST_EOF: begin
          if ((data_in == SOF_BYTE) && par_ok_q && !ovf_q) begin
            commit = 1'b1;
          end else begin
            rollback = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      par_ok_q   <= 1'b0;
      ovf_q      <= 1'b0;
      read_out_q <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_drop_q <= 1'b0;
    end else begin
      pkt_ok_q   <= commit;
      pkt_drop_q <= rollback;
      read_out_q <= (free_cnt >= ROOM_NEED);
      if (wr_en && fifo_full) begin
        ovf_q <= 1'b1;
      end
      if (sw_enable_in) begin
        case (state_q)
          ST_IDLE: begin
            if (data_in == SOF_BYTE) begin
              state_q <= ST_DA;
              ovf_q   <= 1'b0;
            end
          end
          ST_DA: state_q <= ST_SA;
          ST_SA: state_q <= ST_LEN;
          ST_LEN: begin
            if (len_big) begin
              // Skip payload, parity and the closing SOF.
              cnt_q   <= CNT_W'(data_in) + CNT_W'(2);
              state_q <= ST_SKIP;
            end else if (data_in == 8'd0) begin
              state_q <= ST_PAR;
            end else begin
              cnt_q   <= CNT_W'(data_in);
              state_q <= ST_PAY;
            end
          end
          ST_PAY: begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_PAR;
            end
          end
          ST_PAR: begin
            par_ok_q <= par_good;
            state_q  <= ST_EOF;
          end
          ST_EOF: state_q <= ST_IDLE;
          ST_SKIP: begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  parser_commit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (wr_en),
    .wr_entry_i (wr_entry),
    .commit_i   (commit),
    .rollback_i (rollback),
    .rd_en_i    (out_ready),
    .rd_entry_o (rd_entry),
    .rd_valid_o (rd_valid),
    .full_o     (fifo_full),
    .free_o     (free_cnt)
  );

  assign read_out  = read_out_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_drop  = pkt_drop_q;
  assign out_valid = rd_valid;
  assign out_data  = rd_entry.data;
  assign out_sop   = rd_entry.sop;
  assign out_eop   = rd_entry.eop;

endmodule

// File: tb/tb_switch_ingress_parser.sv
// Bench for switch_ingress_parser: directed packet table, hand-written reset and
// overflow sequences, and random packets checked against a packet-level model.
module tb_switch_ingress_parser;

  localparam int FIFO_DEPTH = 64;
  localparam int MAX_LEN    = 16;
`ifdef SWITCH_PARSER_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic [7:0] da;
    logic [7:0] sa;
    logic [7:0] len;
    logic [7:0] seed;
    logic [7:0] flip;
    logic [7:0] close;
    bit         gaps;
    bit         exp_ok;
    bit         exp_drop;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       sw_enable_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       read_out;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_valid;
  logic       pkt_ok;
  logic       pkt_drop;

  int   checks = 0;
  int   passes = 0;
  int   ok_seen = 0;
  int   drop_seen = 0;
  int   ready_mode = 1;
  ent_t exp_q[$];
  vec_t vecs[8];

  switch_ingress_parser #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .data_in      (data_in),
    .sw_enable_in (sw_enable_in),
    .read_out     (read_out),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pkt_ok       (pkt_ok),
    .pkt_drop     (pkt_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pay_byte(input logic [7:0] seed, input int i);
    return seed + 8'(i) * 8'h11;
  endfunction

  // Consumer and pulse counter: out_ready is chosen at the falling edge, so a
  // beat is taken at the next rising edge exactly when valid and ready are both 1.
  always @(negedge clk) begin
    ent_t e;
    case (ready_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    if (pkt_ok) ok_seen++;
    if (pkt_drop) drop_seen++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 32'({out_sop, out_eop, out_data}), 32'({e.sop, e.eop, e.data}));
      end
    end
  end

  task automatic put(input logic [7:0] b, input bit gap);
    @(negedge clk);
    data_in = b;
    sw_enable_in = 1'b1;
    if (gap) begin
      @(negedge clk);
      sw_enable_in = 1'b0;
      data_in = 8'hFF;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sw_enable_in = 1'b0;
      data_in = 8'hFF;
    end
  endtask

  // Parity covers DA, SA, LEN and payload; flip corrupts it on purpose.
  task automatic send_pkt(input logic [7:0] da, sa, len, seed, flip, close,
                          input bit gaps, timing, exp_ok, exp_drop);
    logic [7:0] par;
    int ok0, drop0;
    ok0 = ok_seen;
    drop0 = drop_seen;
    par = da ^ sa ^ len;
    for (int i = 0; i < int'(len); i++) par ^= pay_byte(seed, i);
    if (exp_ok) begin
      exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: da});
      exp_q.push_back('{sop: 1'b0, eop: 1'b0, data: sa});
      exp_q.push_back('{sop: 1'b0, eop: (len == 8'd0), data: len});
      for (int i = 0; i < int'(len); i++)
        exp_q.push_back('{sop: 1'b0, eop: (i == int'(len) - 1), data: pay_byte(seed, i)});
    end
    put(8'hFF, gaps);
    put(da, gaps);
    put(sa, gaps);
    put(len, gaps);
    if (timing && !gaps && int'(len) > MAX_LEN) begin
      @(negedge clk);
      chk("drop_on_len", 32'(pkt_drop), 32'd1);
      sw_enable_in = 1'b0;
    end
    for (int i = 0; i < int'(len); i++) put(pay_byte(seed, i), gaps);
    put(par ^ flip, gaps);
    @(negedge clk);
    if (timing) chk("pre_close_valid", 32'(out_valid), 32'd0);
    data_in = close;
    sw_enable_in = 1'b1;
    if (timing) begin
      @(negedge clk);
      sw_enable_in = 1'b0;
      chk("pkt_ok_n1", 32'(pkt_ok), 32'(exp_ok));
      chk("out_valid_n1", 32'(out_valid), 32'(exp_ok));
    end
    idle(3);
    chk("pkt_ok_count", 32'(ok_seen - ok0), 32'(exp_ok));
    chk("pkt_drop_count", 32'(drop_seen - drop0), 32'(exp_drop));
  endtask

  task automatic drain();
    ready_mode = 2;
    for (int k = 0; k < 400 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_read_out();
    for (int k = 0; k < 400 && !read_out; k++) @(negedge clk);
    chk("read_out_ready", 32'(read_out), 32'd1);
  endtask

  initial begin
    int drop0;
    logic [7:0] len, flip, close;
    bit good;

    vecs[0] = '{8'h01, 8'h02, 8'd2,   8'hAA, 8'h00, 8'hFF, 1'b0, 1'b1,    1'b0};
    vecs[1] = '{8'h01, 8'h02, 8'd2,   8'hAA, 8'h03, 8'hFF, 1'b0, !PAR_EN, PAR_EN};
    vecs[2] = '{8'h03, 8'h04, 8'd0,   8'h00, 8'h00, 8'hFF, 1'b0, 1'b1,    1'b0};
    vecs[3] = '{8'h05, 8'h06, 8'd17,  8'h10, 8'h00, 8'hFF, 1'b0, 1'b0,    1'b1};
    vecs[4] = '{8'h01, 8'h02, 8'd2,   8'hAA, 8'h00, 8'hFF, 1'b1, 1'b1,    1'b0};
    vecs[5] = '{8'h07, 8'h08, 8'd16,  8'h33, 8'h00, 8'hFF, 1'b0, 1'b1,    1'b0};
    vecs[6] = '{8'h09, 8'h0A, 8'd3,   8'h20, 8'h00, 8'h00, 1'b0, 1'b0,    1'b1};
    vecs[7] = '{8'h0B, 8'h0C, 8'd255, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0,    1'b1};

    repeat (3) @(negedge clk);
    chk("rst_read_out", 32'(read_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({out_sop, out_eop, out_data, pkt_ok, pkt_drop}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("read_out_after_rst", 32'(read_out), 32'd1);

    for (int v = 0; v < 8; v++) begin
      ready_mode = 1;
      send_pkt(vecs[v].da, vecs[v].sa, vecs[v].len, vecs[v].seed, vecs[v].flip,
               vecs[v].close, vecs[v].gaps, 1'b1, vecs[v].exp_ok, vecs[v].exp_drop);
      drain();
    end

    // Back-pressure: three 19-byte packets leave 7 free entries, the fourth overflows.
    ready_mode = 1;
    send_pkt(8'h21, 8'h22, 8'd16, 8'h40, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt(8'h23, 8'h24, 8'd16, 8'h41, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("read_out_room", 32'(read_out), 32'd1);
    send_pkt(8'h25, 8'h26, 8'd16, 8'h42, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("read_out_full", 32'(read_out), 32'd0);
    send_pkt(8'h27, 8'h28, 8'd16, 8'h43, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    ready_mode = 0;
    drain();
    idle(2);
    chk("read_out_drained", 32'(read_out), 32'd1);

    // Reset in the middle of a payload with a committed packet still queued.
    ready_mode = 1;
    send_pkt(8'h31, 8'h32, 8'd4, 8'h50, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    drop0 = drop_seen;
    put(8'hFF, 1'b0);
    put(8'h11, 1'b0);
    put(8'h22, 1'b0);
    put(8'd5, 1'b0);
    put(8'h60, 1'b0);
    put(8'h61, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    sw_enable_in = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_read_out", 32'(read_out), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_read_out_back", 32'(read_out), 32'd1);
    chk("midrst_no_drop", 32'(drop_seen - drop0), 32'd0);
    ready_mode = 0;
    send_pkt(8'h41, 8'h42, 8'd3, 8'h70, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random packets with random back-pressure and idle-line garbage.
    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        data_in = 8'($urandom_range(0, 254));
        sw_enable_in = 1'b1;
      end
      idle(1);
      wait_read_out();
      len   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(MAX_LEN + 1, 40))
                                          : 8'($urandom_range(0, MAX_LEN));
      flip  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      close = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF;
      good  = (int'(len) <= MAX_LEN) && (close == 8'hFF) && (!PAR_EN || flip == 8'h00);
      send_pkt(8'($urandom), 8'($urandom), len, 8'($urandom), flip, close,
               1'($urandom_range(0, 1)), 1'b0, good, !good);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
